// File: rtl/cpu_run_ctrl.sv
// Run controller: gates the core clock enable, counts run cycles, detects halt/watchdog,
// then dumps every channel's memory word-by-word over a shared read port onto a valid/ready stream.
`timescale 1ns/1ps
module cpu_run_ctrl #(
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100000,
  parameter int NUM_CH     = 2,
  parameter int DEPTH_W    = 16,
  parameter logic [NUM_CH*DEPTH_W-1:0] CH_DEPTHS = {16'd32, 16'd256},
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpu_halt,
  output logic              cpu_run,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              rd_en,
  output logic [CH_W-1:0]   rd_ch,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [ADDR_W-1:0] out_addr,
  output logic              done,
  output logic [1:0]        status
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_RD_REQ, S_RD_WAIT, S_OUT, S_DONE
  } state_t;

  localparam logic [1:0]     ST_HALT = 2'b01;
  localparam logic [1:0]     ST_TIMEOUT = 2'b10;
  localparam logic [CNT_W:0] MAX_C = (CNT_W+1)'(MAX_CYCLES);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [1:0]        status_d;
  logic              capture;
  logic              run_exit;
  logic [CH_W:0]     nxt;
  logic [CNT_W:0]    cnt_inc;
  logic [ADDR_W-1:0] last_idx;

  function automatic logic [DEPTH_W-1:0] depth_of(input int c);
    return CH_DEPTHS[c*DEPTH_W +: DEPTH_W];
  endfunction

  // Returns {found, channel} for the first non-empty channel at or above 'from'.
  function automatic logic [CH_W:0] find_ch(input int from);
    logic [CH_W:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!r[CH_W] && i >= from && depth_of(i) != '0) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

  assign cnt_inc  = {1'b0, cycle_count} + {{CNT_W{1'b0}}, 1'b1};
  assign last_idx = ADDR_W'(depth_of(int'(ch_q))) - {{(ADDR_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    idx_d    = idx_q;
    cnt_d    = cycle_count;
    status_d = status;
    capture  = 1'b0;
    run_exit = 1'b0;
    nxt      = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          status_d = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc[CNT_W] ? cycle_count : cnt_inc[CNT_W-1:0];
        if (cpu_halt) begin
          status_d = ST_HALT;
          run_exit = 1'b1;
        end else if (MAX_CYCLES != 0 && cnt_inc == MAX_C) begin
          status_d = ST_TIMEOUT;
          run_exit = 1'b1;
        end
        if (run_exit) begin
          nxt     = find_ch(0);
          ch_d    = nxt[CH_W-1:0];
          idx_d   = '0;
          state_d = nxt[CH_W] ? S_RD_REQ : S_DONE;
        end
      end
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        capture = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (idx_q != last_idx) begin
            idx_d   = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_d = S_RD_REQ;
          end else begin
            nxt = find_ch(int'(ch_q) + 1);
            if (nxt[CH_W]) begin
              ch_d    = nxt[CH_W-1:0];
              idx_d   = '0;
              state_d = S_RD_REQ;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      idx_q       <= '0;
      cycle_count <= '0;
      status      <= '0;
      out_data    <= '0;
      out_ch      <= '0;
      out_addr    <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      idx_q       <= idx_d;
      cycle_count <= cnt_d;
      status      <= status_d;
      if (capture) begin
        out_data <= rd_data;
        out_ch   <= ch_q;
        out_addr <= idx_q;
      end
    end
  end

  // Strobes decode straight from state so an async reset clears them immediately.
  assign cpu_run   = (state_q == S_RUN);
  assign rd_en     = (state_q == S_RD_REQ);
  assign out_valid = (state_q == S_OUT);
  assign done      = (state_q == S_DONE);
  assign rd_ch     = ch_q;
  assign rd_addr   = idx_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: three instances cover normal/watchdog depths, an empty ch0 and all-empty dumps.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_halt = 1'b0;
  logic out_ready = 1'b1;
  logic [2:0] start_v = 3'b000;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sel = 0;
  int exp_ch[8];
  int exp_addr[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic run_a, rd_en_a, valid_a, done_a; logic [0:0] rd_ch_a, och_a; logic [1:0] st_a;
  logic [31:0] cnt_a, rd_addr_a, odata_a, oaddr_a; logic [31:0] rd_data_a = '0;
  logic run_b, rd_en_b, valid_b, done_b; logic [0:0] rd_ch_b, och_b; logic [1:0] st_b;
  logic [31:0] cnt_b, rd_addr_b, odata_b, oaddr_b; logic [31:0] rd_data_b = '0;
  logic run_c, rd_en_c, valid_c, done_c; logic [0:0] rd_ch_c, och_c; logic [1:0] st_c;
  logic [31:0] cnt_c, rd_addr_c, odata_c, oaddr_c; logic [31:0] rd_data_c = '0;

  cpu_run_ctrl #(.MAX_CYCLES(20), .CH_DEPTHS({16'd2, 16'd3})) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .cpu_halt(cpu_halt), .cpu_run(run_a),
    .cycle_count(cnt_a), .rd_en(rd_en_a), .rd_ch(rd_ch_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .out_valid(valid_a), .out_ready(out_ready), .out_data(odata_a),
    .out_ch(och_a), .out_addr(oaddr_a), .done(done_a), .status(st_a));

  cpu_run_ctrl #(.MAX_CYCLES(0), .CH_DEPTHS({16'd4, 16'd0})) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .cpu_halt(cpu_halt), .cpu_run(run_b),
    .cycle_count(cnt_b), .rd_en(rd_en_b), .rd_ch(rd_ch_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .out_valid(valid_b), .out_ready(out_ready), .out_data(odata_b),
    .out_ch(och_b), .out_addr(oaddr_b), .done(done_b), .status(st_b));

  cpu_run_ctrl #(.MAX_CYCLES(0), .CH_DEPTHS({16'd0, 16'd0})) dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .cpu_halt(cpu_halt), .cpu_run(run_c),
    .cycle_count(cnt_c), .rd_en(rd_en_c), .rd_ch(rd_ch_c), .rd_addr(rd_addr_c),
    .rd_data(rd_data_c), .out_valid(valid_c), .out_ready(out_ready), .out_data(odata_c),
    .out_ch(och_c), .out_addr(oaddr_c), .done(done_c), .status(st_c));

  // Memory models: word = addr + 0x100*ch, one cycle after the strobe.
  always @(posedge clk) if (rd_en_a) rd_data_a <= rd_addr_a + (rd_ch_a[0] ? 32'h100 : 32'h0);
  always @(posedge clk) if (rd_en_b) rd_data_b <= rd_addr_b + (rd_ch_b[0] ? 32'h100 : 32'h0);
  always @(posedge clk) if (rd_en_c) rd_data_c <= rd_addr_c + (rd_ch_c[0] ? 32'h100 : 32'h0);

  logic m_run, m_rd_en, m_valid, m_done; logic [0:0] m_rd_ch, m_ch; logic [1:0] m_st;
  logic [31:0] m_cnt, m_rd_addr, m_data, m_addr;
  always_comb begin
    {m_run, m_rd_en, m_valid, m_done, m_rd_ch, m_ch, m_st} = '0;
    {m_cnt, m_rd_addr, m_data, m_addr} = '0;
    case (sel)
      0: begin
        {m_run, m_rd_en, m_valid, m_done, m_rd_ch, m_ch, m_st} = {run_a, rd_en_a, valid_a, done_a, rd_ch_a, och_a, st_a};
        {m_cnt, m_rd_addr, m_data, m_addr} = {cnt_a, rd_addr_a, odata_a, oaddr_a};
      end
      1: begin
        {m_run, m_rd_en, m_valid, m_done, m_rd_ch, m_ch, m_st} = {run_b, rd_en_b, valid_b, done_b, rd_ch_b, och_b, st_b};
        {m_cnt, m_rd_addr, m_data, m_addr} = {cnt_b, rd_addr_b, odata_b, oaddr_b};
      end
      default: begin
        {m_run, m_rd_en, m_valid, m_done, m_rd_ch, m_ch, m_st} = {run_c, rd_en_c, valid_c, done_c, rd_ch_c, och_c, st_c};
        {m_cnt, m_rd_addr, m_data, m_addr} = {cnt_c, rd_addr_c, odata_c, oaddr_c};
      end
    endcase
  end

  task automatic pulse_start();
    start_v[sel] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
  endtask

  // Drives n RUN cycles; optional halt on the last one and a stray start at cycle start_at.
  task automatic run_core(input int n, input bit halt, input int start_at);
    for (int k = 1; k <= n; k++) begin
      checks++;
      if (m_run !== 1'b1 || m_cnt !== 32'(k - 1)) begin
        errors++;
        $display("FAIL run_cycle%0d: cpu_run=%b count=%0d, required 1 and %0d", k, m_run, m_cnt, k - 1);
      end
      start_v[sel] = (k == start_at);
      cpu_halt = halt && (k == n);
      @(posedge clk); #1;
    end
    cpu_halt = 1'b0;
    start_v = '0;
  endtask

  task automatic drain(input int n, input int stall_w, input int stall_len);
    int waited;
    int last;
    logic [31:0] hold_d, hold_a, exp_d;
    last = -1;
    out_ready = 1'b1;
    for (int w = 0; w < n; w++) begin
      waited = 0;
      while (!m_valid && waited < 20) begin
        @(posedge clk); #1;
        waited++;
      end
      exp_d = 32'(exp_addr[w]) + 32'h100 * 32'(exp_ch[w]);
      checks++;
      if (m_valid !== 1'b1 || m_ch !== 1'(exp_ch[w]) || m_addr !== 32'(exp_addr[w]) || m_data !== exp_d) begin
        errors++;
        $display("FAIL word%0d: valid=%b ch=%0d addr=%0d data=%h, required 1 %0d %0d %h",
                 w, m_valid, m_ch, m_addr, m_data, exp_ch[w], exp_addr[w], exp_d);
      end
      if (last >= 0 && w != stall_w + 1) begin
        checks++;
        if (cyc - last != 3) begin
          errors++;
          $display("FAIL word%0d_spacing: %0d cycles, required 3", w, cyc - last);
        end
      end
      last = cyc;
      if (w == stall_w) begin
        hold_d = m_data;
        hold_a = m_addr;
        out_ready = 1'b0;
        repeat (stall_len) begin
          @(posedge clk); #1;
          checks++;
          if (m_valid !== 1'b1 || m_rd_en !== 1'b0 || m_data !== hold_d || m_addr !== hold_a) begin
            errors++;
            $display("FAIL stall: valid=%b rd_en=%b data=%h addr=%0d, required 1 0 %h %0d",
                     m_valid, m_rd_en, m_data, m_addr, hold_d, hold_a);
          end
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_done(input string name, input logic [31:0] cnt, input logic [1:0] st);
    checks++;
    if (m_done !== 1'b1 || m_valid !== 1'b0 || m_run !== 1'b0 || m_cnt !== cnt || m_st !== st) begin
      errors++;
      $display("FAIL %s: done=%b valid=%b run=%b count=%0d status=%b, required 1 0 0 %0d %b",
               name, m_done, m_valid, m_run, m_cnt, m_st, cnt, st);
    end
  endtask

  task automatic test_reset();
    sel = 0;
    #3;
    checks++;
    if ({run_a, rd_en_a, valid_a, done_a, st_a} !== 6'b0 || cnt_a !== 32'd0 || odata_a !== 32'd0) begin
      errors++;
      $display("FAIL reset_a: run=%b rd_en=%b valid=%b done=%b status=%b count=%0d, required all 0",
               run_a, rd_en_a, valid_a, done_a, st_a, cnt_a);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({run_b, done_b, run_c, done_c, rd_en_b, valid_c} !== 6'b0) begin
      errors++;
      $display("FAIL idle_after_reset: run_b=%b done_b=%b run_c=%b done_c=%b, required 0", run_b, done_b, run_c, done_c);
    end
  endtask

  task automatic test_halt_run();
    sel = 0;
    exp_ch = '{0, 0, 0, 1, 1, 0, 0, 0};
    exp_addr = '{0, 1, 2, 0, 1, 0, 0, 0};
    pulse_start();
    run_core(10, 1'b1, 5);
    checks++;
    if (m_run !== 1'b0 || m_cnt !== 32'd10 || m_st !== 2'b01 || m_rd_en !== 1'b1 || m_rd_ch !== 1'b0 || m_rd_addr !== 32'd0) begin
      errors++;
      $display("FAIL halt_exit: run=%b count=%0d status=%b rd_en=%b rd_ch=%0d rd_addr=%0d, required 0 10 01 1 0 0",
               m_run, m_cnt, m_st, m_rd_en, m_rd_ch, m_rd_addr);
    end
    drain(5, -1, 0);
    check_done("halt_done", 32'd10, 2'b01);
    @(posedge clk); #1;
    check_done("halt_done_held", 32'd10, 2'b01);
  endtask

  task automatic test_restart_watchdog();
    sel = 0;
    pulse_start();
    checks++;
    if (m_done !== 1'b0 || m_st !== 2'b00) begin
      errors++;
      $display("FAIL restart: done=%b status=%b, required 0 00", m_done, m_st);
    end
    run_core(20, 1'b0, 0);
    checks++;
    if (m_run !== 1'b0 || m_cnt !== 32'd20 || m_st !== 2'b10) begin
      errors++;
      $display("FAIL watchdog_exit: run=%b count=%0d status=%b, required 0 20 10", m_run, m_cnt, m_st);
    end
    drain(5, 1, 5);
    check_done("watchdog_done", 32'd20, 2'b10);
  endtask

  task automatic test_watchdog_halt();
    sel = 0;
    pulse_start();
    run_core(20, 1'b1, 0);
    checks++;
    if (m_cnt !== 32'd20 || m_st !== 2'b01) begin
      errors++;
      $display("FAIL halt_vs_limit: count=%0d status=%b, required 20 01", m_cnt, m_st);
    end
    drain(5, -1, 0);
    check_done("halt_vs_limit_done", 32'd20, 2'b01);
  endtask

  task automatic test_zero_depth();
    sel = 1;
    exp_ch = '{1, 1, 1, 1, 0, 0, 0, 0};
    exp_addr = '{0, 1, 2, 3, 0, 0, 0, 0};
    pulse_start();
    run_core(3, 1'b1, 0);
    checks++;
    if (m_rd_en !== 1'b1 || m_rd_ch !== 1'b1 || m_rd_addr !== 32'd0 || m_cnt !== 32'd3 || m_st !== 2'b01) begin
      errors++;
      $display("FAIL skip_ch0: rd_en=%b rd_ch=%0d rd_addr=%0d count=%0d status=%b, required 1 1 0 3 01",
               m_rd_en, m_rd_ch, m_rd_addr, m_cnt, m_st);
    end
    drain(4, -1, 0);
    check_done("zero_depth_done", 32'd3, 2'b01);
  endtask

  task automatic test_all_zero();
    sel = 2;
    pulse_start();
    run_core(1, 1'b1, 0);
    checks++;
    if (m_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL all_zero_rd_en: rd_en=%b, required 0", m_rd_en);
    end
    check_done("all_zero_done", 32'd1, 2'b01);
  endtask

  task automatic test_reset_mid_dump();
    int waited;
    sel = 0;
    exp_ch = '{0, 0, 0, 1, 1, 0, 0, 0};
    exp_addr = '{0, 1, 2, 0, 1, 0, 0, 0};
    pulse_start();
    run_core(2, 1'b1, 0);
    drain(2, -1, 0);
    waited = 0;
    while (!m_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (m_valid !== 1'b1 || m_addr !== 32'd2) begin
      errors++;
      $display("FAIL pre_reset_word2: valid=%b addr=%0d, required 1 2", m_valid, m_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({m_run, m_rd_en, m_valid, m_done, m_st, m_ch, m_rd_ch} !== 8'b0 ||
        m_cnt !== 32'd0 || m_data !== 32'd0 || m_addr !== 32'd0 || m_rd_addr !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: run=%b rd_en=%b valid=%b done=%b status=%b count=%0d data=%h addr=%0d, required all 0",
               m_run, m_rd_en, m_valid, m_done, m_st, m_cnt, m_data, m_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    pulse_start();
    run_core(3, 1'b1, 0);
    drain(5, -1, 0);
    check_done("after_reset_done", 32'd3, 2'b01);
  endtask

  initial begin
    test_reset();
    test_halt_run();
    test_restart_watchdog();
    test_watchdog_halt();
    test_zero_depth();
    test_all_zero();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded 100000 ns");
    $fatal(1, "timeout");
  end

endmodule
